// File: rtl/alu_step_ctrl.sv
// rtl/alu_step_ctrl.sv - button debounce and A/B/opcode entry sequencer for the board ALU
// Produces one-cycle pb1/pb2/pb3 load/execute strobes alongside a registered switch value.

module alu_step_db #(
  parameter int DB_COUNT = 4,
  parameter int DB_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);
  logic            s1, s2, db, armed;
  logic [1:0]      prim;
  logic [DB_W-1:0] cnt;

  // armed blocks the first rising edge when the button is already held as reset
  // releases; prim[1] marks s2 as holding a genuine post-reset sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      armed <= 1'b0;
      prim  <= 2'b00;
      cnt   <= '0;
      evt   <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prim <= {prim[0], 1'b1};
      evt  <= 1'b0;
      if (prim[1] && !s2) armed <= 1'b1;
      if (s2 != db) begin
        if (cnt == DB_W'(DB_COUNT - 1)) begin
          db  <= s2;
          cnt <= '0;
          evt <= s2 & armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module alu_step_ctrl #(
  parameter int DB_COUNT = 4,
  parameter int DB_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_clr,
  input  logic [7:0] sw,
  output logic       pb1,
  output logic       pb2,
  output logic       pb3,
  output logic [7:0] sw_out,
  output logic [3:0] m_3,
  output logic       op_err,
  output logic [7:0] op_count,
  output logic [1:0] stage
);
  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    SHOW   = 2'd3
  } state_t;

  state_t     state, state_n;
  logic       next_evt, clr_evt;
  logic       pb1_n, pb2_n, pb3_n, op_err_n, valid_op;
  logic [7:0] sw_out_n, op_count_n;

  alu_step_db #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_next (
    .clk(clk), .rst(rst), .btn(btn_next), .evt(next_evt)
  );

  alu_step_db #(.DB_COUNT(DB_COUNT), .DB_W(DB_W)) u_db_clr (
    .clk(clk), .rst(rst), .btn(btn_clr), .evt(clr_evt)
  );

  assign valid_op = (sw[2:0] != 3'b000) && (sw[2:0] != 3'b111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GET_A;
      pb1      <= 1'b0;
      pb2      <= 1'b0;
      pb3      <= 1'b0;
      sw_out   <= 8'h00;
      op_err   <= 1'b0;
      op_count <= 8'h00;
    end else begin
      state    <= state_n;
      pb1      <= pb1_n;
      pb2      <= pb2_n;
      pb3      <= pb3_n;
      sw_out   <= sw_out_n;
      op_err   <= op_err_n;
      op_count <= op_count_n;
    end
  end

  // clear wins over a coincident next, which is dropped
  always_comb begin
    state_n    = state;
    pb1_n      = 1'b0;
    pb2_n      = 1'b0;
    pb3_n      = 1'b0;
    sw_out_n   = sw_out;
    op_err_n   = op_err;
    op_count_n = op_count;
    if (clr_evt) begin
      state_n  = GET_A;
      op_err_n = 1'b0;
    end else if (next_evt) begin
      case (state)
        GET_A: begin
          sw_out_n = sw;
          pb1_n    = 1'b1;
          state_n  = GET_B;
        end
        GET_B: begin
          sw_out_n = sw;
          pb2_n    = 1'b1;
          state_n  = GET_OP;
        end
        GET_OP: begin
          if (valid_op) begin
            sw_out_n   = sw;
            pb3_n      = 1'b1;
            op_err_n   = 1'b0;
            op_count_n = op_count + 8'd1;
            state_n    = SHOW;
          end else begin
            op_err_n = 1'b1;
          end
        end
        SHOW:    state_n = GET_A;
        default: state_n = GET_A;
      endcase
    end
  end

  always_comb begin
    m_3 = 4'hA;
    case (state)
      GET_A:   m_3 = 4'hA;
      GET_B:   m_3 = 4'hB;
      GET_OP:  m_3 = 4'hC;
      SHOW:    m_3 = 4'hD;
      default: m_3 = 4'hA;
    endcase
  end

  assign stage = state;
endmodule

// File: tb/tb_alu_step_ctrl.sv
// tb/tb_alu_step_ctrl.sv - directed self-checking bench for alu_step_ctrl
module tb_alu_step_ctrl;
  localparam int DB = 4;

  logic       clk, rst, btn_next, btn_clr;
  logic [7:0] sw;
  logic       pb1, pb2, pb3, op_err;
  logic [7:0] sw_out, op_count;
  logic [3:0] m_3;
  logic [1:0] stage;

  int total = 0;
  int bad   = 0;
  int c1, c2, c3, f1, f2, f3, multi;
  logic [7:0] v1, v2, v3;
  logic [7:0] alu_a, alu_b, alu_res;

  alu_step_ctrl #(.DB_COUNT(DB), .DB_W(20)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_clr(btn_clr), .sw(sw),
    .pb1(pb1), .pb2(pb2), .pb3(pb3), .sw_out(sw_out), .m_3(m_3),
    .op_err(op_err), .op_count(op_count), .stage(stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_obs();
    c1 = 0; c2 = 0; c3 = 0; f1 = -1; f2 = -1; f3 = -1;
    v1 = 8'hxx; v2 = 8'hxx; v3 = 8'hxx;
  endtask

  // advance n edges, sampling strobes at the following negedge; index = edge number
  task automatic run_cycles(input int n, input int base);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((int'(pb1) + int'(pb2) + int'(pb3)) > 1) multi++;
      if (pb1) begin c1++; v1 = sw_out; if (f1 < 0) f1 = base + i; end
      if (pb2) begin c2++; v2 = sw_out; if (f2 < 0) f2 = base + i; end
      if (pb3) begin c3++; v3 = sw_out; if (f3 < 0) f3 = base + i; end
    end
  endtask

  task automatic press(input logic clr, input logic nxt, input logic [7:0] v,
                       input int hold, input int rel);
    clear_obs();
    sw = v;
    btn_next = nxt;
    btn_clr = clr;
    run_cycles(hold, 0);
    btn_next = 1'b0;
    btn_clr = 1'b0;
    run_cycles(rel, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (pb1 !== 1'b0 || pb2 !== 1'b0 || pb3 !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b%b exp=000", pb1, pb2, pb3); end
    total++; if (sw_out !== 8'h00) begin bad++; $display("FAIL reset_sw_out got=%h exp=00", sw_out); end
    total++; if (m_3 !== 4'hA) begin bad++; $display("FAIL reset_m_3 got=%h exp=a", m_3); end
    total++; if (op_err !== 1'b0 || op_count !== 8'h00) begin bad++; $display("FAIL reset_op got=%b/%h exp=0/00", op_err, op_count); end
    total++; if (stage !== 2'd0) begin bad++; $display("FAIL reset_stage got=%0d exp=0", stage); end
    rst = 1'b0;
    run_cycles(6, 0);
  endtask

  task automatic test_sequence();
    press(1'b0, 1'b1, 8'h25, 12, DB + 6);
    total++; if (c1 !== 1 || c2 !== 0 || c3 !== 0) begin bad++; $display("FAIL seq_a_strobes got=%0d/%0d/%0d exp=1/0/0", c1, c2, c3); end
    total++; if (f1 !== DB + 3) begin bad++; $display("FAIL seq_a_latency got=%0d exp=%0d", f1, DB + 3); end
    total++; if (v1 !== 8'h25 || m_3 !== 4'hB) begin bad++; $display("FAIL seq_a_data got=%h/%h exp=25/b", v1, m_3); end
    alu_a = v1;
    press(1'b0, 1'b1, 8'h13, 12, DB + 6);
    total++; if (c2 !== 1 || c1 !== 0 || c3 !== 0 || v2 !== 8'h13) begin bad++; $display("FAIL seq_b got=%0d/%h exp=1/13", c2, v2); end
    total++; if (m_3 !== 4'hC || stage !== 2'd2) begin bad++; $display("FAIL seq_b_stage got=%h/%0d exp=c/2", m_3, stage); end
    alu_b = v2;
    press(1'b0, 1'b1, 8'h01, 12, DB + 6);
    total++; if (c3 !== 1 || c1 !== 0 || c2 !== 0 || v3 !== 8'h01) begin bad++; $display("FAIL seq_op got=%0d/%h exp=1/01", c3, v3); end
    total++; if (m_3 !== 4'hD || op_count !== 8'd1) begin bad++; $display("FAIL seq_op_state got=%h/%0d exp=d/1", m_3, op_count); end
    alu_res = (v3[2:0] == 3'b001) ? alu_a + alu_b : 8'h00;
    total++; if (alu_res !== 8'h38) begin bad++; $display("FAIL seq_alu_result got=%h exp=38", alu_res); end
    press(1'b0, 1'b1, 8'hF0, 12, DB + 6);
    total++; if (c1 + c2 + c3 !== 0 || stage !== 2'd0 || sw_out !== 8'h01) begin bad++; $display("FAIL seq_show got=%0d/%0d/%h exp=0/0/01", c1 + c2 + c3, stage, sw_out); end
  endtask

  task automatic test_bounce();
    clear_obs();
    sw = 8'h44;
    btn_next = 1'b1; run_cycles(2, 0);
    btn_next = 1'b0; run_cycles(1, 2);
    btn_next = 1'b1; run_cycles(2, 3);
    btn_next = 1'b0; run_cycles(1, 5);
    btn_next = 1'b1; run_cycles(10, 6);
    btn_next = 1'b0; run_cycles(DB + 8, 16);
    total++; if (c1 !== 1 || c2 !== 0) begin bad++; $display("FAIL bounce_count got=%0d/%0d exp=1/0", c1, c2); end
    total++; if (f1 !== 6 + DB + 3) begin bad++; $display("FAIL bounce_latency got=%0d exp=%0d", f1, 6 + DB + 3); end
    total++; if (v1 !== 8'h44 || stage !== 2'd1) begin bad++; $display("FAIL bounce_state got=%h/%0d exp=44/1", v1, stage); end
  endtask

  task automatic test_bad_op();
    press(1'b0, 1'b1, 8'h02, 12, DB + 6);
    press(1'b0, 1'b1, 8'h07, 12, DB + 6);
    total++; if (c3 !== 0 || op_err !== 1'b1 || stage !== 2'd2) begin bad++; $display("FAIL badop_reject got=%0d/%b/%0d exp=0/1/2", c3, op_err, stage); end
    total++; if (sw_out !== 8'h02) begin bad++; $display("FAIL badop_sw_out got=%h exp=02", sw_out); end
    press(1'b0, 1'b1, 8'h06, 12, DB + 6);
    total++; if (c3 !== 1 || v3 !== 8'h06 || op_err !== 1'b0 || stage !== 2'd3) begin bad++; $display("FAIL badop_accept got=%0d/%h/%b/%0d exp=1/06/0/3", c3, v3, op_err, stage); end
    total++; if (op_count !== 8'd2) begin bad++; $display("FAIL badop_count got=%0d exp=2", op_count); end
  endtask

  task automatic test_clr_priority();
    press(1'b0, 1'b1, 8'h00, 12, DB + 6);
    press(1'b0, 1'b1, 8'h0A, 12, DB + 6);
    press(1'b0, 1'b1, 8'h0B, 12, DB + 6);
    press(1'b0, 1'b1, 8'h00, 12, DB + 6);
    total++; if (op_err !== 1'b1 || stage !== 2'd2) begin bad++; $display("FAIL clr_setup got=%b/%0d exp=1/2", op_err, stage); end
    press(1'b1, 1'b1, 8'h03, 12, DB + 6);
    total++; if (c1 + c2 + c3 !== 0) begin bad++; $display("FAIL clr_strobes got=%0d exp=0", c1 + c2 + c3); end
    total++; if (stage !== 2'd0 || m_3 !== 4'hA || op_err !== 1'b0) begin bad++; $display("FAIL clr_state got=%0d/%h/%b exp=0/a/0", stage, m_3, op_err); end
    total++; if (sw_out !== 8'h0B || op_count !== 8'd2) begin bad++; $display("FAIL clr_hold got=%h/%0d exp=0b/2", sw_out, op_count); end
  endtask

  task automatic test_wrap();
    int n3;
    n3 = 0;
    for (int k = 0; k < 254; k++) begin
      press(1'b0, 1'b1, 8'(k), 8, 8);
      press(1'b0, 1'b1, 8'(k + 1), 8, 8);
      if (k == 253) begin
        total++; if (op_count !== 8'hFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ff", op_count); end
      end
      press(1'b0, 1'b1, {5'b0, 3'((k % 6) + 1)}, 8, 8);
      n3 += c3;
      press(1'b0, 1'b1, 8'h00, 8, 8);
    end
    total++; if (n3 !== 254) begin bad++; $display("FAIL wrap_pb3_count got=%0d exp=254", n3); end
    total++; if (op_count !== 8'h00) begin bad++; $display("FAIL wrap_count got=%h exp=00", op_count); end
    total++; if (multi !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", multi); end
  endtask

  task automatic test_reset_mid();
    int seen;
    press(1'b0, 1'b1, 8'h11, 12, DB + 6);
    press(1'b0, 1'b1, 8'h22, 12, DB + 6);
    press(1'b0, 1'b1, 8'h01, 12, DB + 6);
    press(1'b0, 1'b1, 8'h00, 12, DB + 6);
    press(1'b0, 1'b1, 8'h33, 12, DB + 6);
    total++; if (op_count !== 8'd1 || stage !== 2'd1) begin bad++; $display("FAIL rstmid_setup got=%0d/%0d exp=1/1", op_count, stage); end
    sw = 8'h55;
    btn_next = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pb2) seen = 1;
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL rstmid_pb2_seen got=%0d exp=1", seen); end
    rst = 1'b1;
    #1;
    total++; if (pb2 !== 1'b0 || sw_out !== 8'h00 || stage !== 2'd0) begin bad++; $display("FAIL rstmid_immediate got=%b/%h/%0d exp=0/00/0", pb2, sw_out, stage); end
    total++; if (m_3 !== 4'hA || op_count !== 8'h00 || op_err !== 1'b0) begin bad++; $display("FAIL rstmid_regs got=%h/%h/%b exp=a/00/0", m_3, op_count, op_err); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    run_cycles(20, 0);
    total++; if (c1 + c2 + c3 !== 0 || stage !== 2'd0) begin bad++; $display("FAIL rstmid_held got=%0d/%0d exp=0/0", c1 + c2 + c3, stage); end
    btn_next = 1'b0;
    run_cycles(10, 0);
    press(1'b0, 1'b1, 8'h66, 12, DB + 6);
    total++; if (c1 !== 1 || v1 !== 8'h66) begin bad++; $display("FAIL rstmid_repress got=%0d/%h exp=1/66", c1, v1); end
  endtask

  initial begin
    rst = 1'b1; btn_next = 1'b0; btn_clr = 1'b0; sw = 8'h00;
    multi = 0;
    clear_obs();
    test_reset();
    test_sequence();
    test_bounce();
    test_bad_op();
    test_clr_priority();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
